alu_decode_stage: RTL and testbench

//  Decode/operand-select stage directly upstream of the RV64IM ALU.
//  - Accepts one 32-bit instruction per cycle, plus rs1/rs2 register-file data.
//  - Produces the ALU opcode (alu_control), operand A, and operand B (register
//    or sign-extended immediate).
//  - Holds results in a single-entry valid/ready pipeline register; the execute

---
 rtl/alu_decode_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Decode/operand-select stage feeding the RV64IM ALU: turns one instruction per
// cycle into an ALU opcode plus operands, held in a one-entry valid/ready register.
module alu_decode_stage #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter int ILL_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_WIDTH-1:0]    in_instr,
  input  logic [BUS_DATA_WIDTH-1:0] rs1_data,
  input  logic [BUS_DATA_WIDTH-1:0] rs2_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_DATA_WIDTH-1:0] dataA,
  output logic [BUS_DATA_WIDTH-1:0] dataB,
  output logic [5:0]                alu_control,
  output logic [4:0]                rd,
  output logic                      rd_we,
  output logic                      illegal,
  output logic [ILL_CNT_WIDTH-1:0]  ill_count
);

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  typedef enum logic [1:0] {
    OPB_REG,
    OPB_IMM,
    OPB_SH6,
    OPB_SH5
  } opbSel_t;

  logic [6:0]                w_opcode;
  logic [2:0]                w_funct3;
  logic [6:0]                w_funct7;
  logic [4:0]                w_unusedRs1Field;
  logic [5:0]                w_aluCtrl;
  logic                      w_legal;
  opbSel_t                   w_opbSel;
  logic [BUS_DATA_WIDTH-1:0] w_opB;
  logic [BUS_DATA_WIDTH-1:0] w_dataA;
  logic [BUS_DATA_WIDTH-1:0] w_dataB;
  logic [4:0]                w_rd;
  logic                      w_rdWe;
  logic                      w_load;

  logic                      r_outValid;
  logic [BUS_DATA_WIDTH-1:0] r_dataA;
  logic [BUS_DATA_WIDTH-1:0] r_dataB;
  logic [5:0]                r_aluCtrl;
  logic [4:0]                r_rd;
  logic                      r_rdWe;
  logic                      r_illegal;
  logic [ILL_CNT_WIDTH-1:0]  r_illCount;

  assign w_opcode         = in_instr[6:0];
  assign w_funct3         = in_instr[14:12];
  assign w_funct7         = in_instr[31:25];
  assign w_unusedRs1Field = in_instr[19:15];

  // Opcode decode; any branch that does not land on a listed encoding leaves w_legal low.
  always_comb begin
    w_aluCtrl = 6'd0;
    w_legal   = 1'b0;
    w_opbSel  = OPB_REG;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_legal  = 1'b1;
        w_opbSel = OPB_IMM;
        case (w_funct3)
          3'b000: w_aluCtrl = 6'd1;
          3'b010: w_aluCtrl = 6'd2;
          3'b011: w_aluCtrl = 6'd3;
          3'b100: w_aluCtrl = 6'd4;
          3'b110: w_aluCtrl = 6'd5;
          3'b111: w_aluCtrl = 6'd6;
          3'b001: begin
            w_opbSel = OPB_SH6;
            if (in_instr[31:26] == 6'b000000) w_aluCtrl = 6'd7;
            else                              w_legal   = 1'b0;
          end
          default: begin
            w_opbSel = OPB_SH6;
            if (in_instr[31:26] == 6'b000000)      w_aluCtrl = 6'd8;
            else if (in_instr[31:26] == 6'b010000) w_aluCtrl = 6'd9;
            else                                   w_legal   = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'b000:  w_aluCtrl = 6'd12;
            3'b001:  w_aluCtrl = 6'd14;
            3'b010:  w_aluCtrl = 6'd15;
            3'b011:  w_aluCtrl = 6'd16;
            3'b100:  w_aluCtrl = 6'd17;
            3'b101:  w_aluCtrl = 6'd18;
            3'b110:  w_aluCtrl = 6'd20;
            default: w_aluCtrl = 6'd21;
          endcase
        end else if (w_funct7 == F7_ALT) begin
          if (w_funct3 == 3'b000) begin
            w_legal   = 1'b1;
            w_aluCtrl = 6'd13;
          end else if (w_funct3 == 3'b101) begin
            w_legal   = 1'b1;
            w_aluCtrl = 6'd19;
          end
        end else if (w_funct7 == F7_MULD) begin
          w_legal   = 1'b1;
          w_aluCtrl = 6'd31 + {3'b000, w_funct3};
        end
      end
      OPC_OP_IMM_32: begin
        case (w_funct3)
          3'b000: begin
            w_legal   = 1'b1;
            w_opbSel  = OPB_IMM;
            w_aluCtrl = 6'd22;
          end
          3'b001: begin
            w_opbSel = OPB_SH5;
            if (w_funct7 == F7_BASE) begin
              w_legal   = 1'b1;
              w_aluCtrl = 6'd23;
            end
          end
          3'b101: begin
            w_opbSel = OPB_SH5;
            if (w_funct7 == F7_BASE) begin
              w_legal   = 1'b1;
              w_aluCtrl = 6'd24;
            end else if (w_funct7 == F7_ALT) begin
              w_legal   = 1'b1;
              w_aluCtrl = 6'd25;
            end
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
          case ({w_funct7 == F7_ALT, w_funct3})
            4'b0_000: begin w_legal = 1'b1; w_aluCtrl = 6'd26; end
            4'b1_000: begin w_legal = 1'b1; w_aluCtrl = 6'd27; end
            4'b0_001: begin w_legal = 1'b1; w_aluCtrl = 6'd28; end
            4'b0_101: begin w_legal = 1'b1; w_aluCtrl = 6'd29; end
            4'b1_101: begin w_legal = 1'b1; w_aluCtrl = 6'd30; end
            default:  w_legal = 1'b0;
          endcase
        end else if (w_funct7 == F7_MULD) begin
          case (w_funct3)
            3'b000:  begin w_legal = 1'b1; w_aluCtrl = 6'd39; end
            3'b100:  begin w_legal = 1'b1; w_aluCtrl = 6'd40; end
            3'b101:  begin w_legal = 1'b1; w_aluCtrl = 6'd41; end
            3'b110:  begin w_legal = 1'b1; w_aluCtrl = 6'd42; end
            3'b111:  begin w_legal = 1'b1; w_aluCtrl = 6'd43; end
            default: w_legal = 1'b0;
          endcase
        end
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) w_aluCtrl = 6'd0;
  end

  always_comb begin
    w_opB = rs2_data;
    case (w_opbSel)
      OPB_IMM: w_opB = {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
      OPB_SH6: w_opB = {{(BUS_DATA_WIDTH-6){1'b0}}, in_instr[25:20]};
      OPB_SH5: w_opB = {{(BUS_DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
      default: w_opB = rs2_data;
    endcase
  end

  // Illegal entries still travel downstream, but carry no operands and no writeback.
  assign w_dataA = w_legal ? rs1_data : '0;
  assign w_dataB = w_legal ? w_opB : '0;
  assign w_rd    = in_instr[11:7];
  assign w_rdWe  = w_legal && (w_rd != 5'd0);

  assign in_ready = !r_outValid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  // Flush wins over load and pop; the counter only sees instructions that were really taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_dataA    <= '0;
      r_dataB    <= '0;
      r_aluCtrl  <= 6'd0;
      r_rd       <= 5'd0;
      r_rdWe     <= 1'b0;
      r_illegal  <= 1'b0;
      r_illCount <= '0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_dataA    <= w_dataA;
      r_dataB    <= w_dataB;
      r_aluCtrl  <= w_aluCtrl;
      r_rd       <= w_rd;
      r_rdWe     <= w_rdWe;
      r_illegal  <= !w_legal;
      if (!w_legal && (r_illCount != {ILL_CNT_WIDTH{1'b1}}))
        r_illCount <= r_illCount + ILL_CNT_WIDTH'(1);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid   = r_outValid;
  assign dataA       = r_dataA;
  assign dataB       = r_dataB;
  assign alu_control = r_aluCtrl;
  assign rd          = r_rd;
  assign rd_we       = r_rdWe;
  assign illegal     = r_illegal;
  assign ill_count   = r_illCount;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomised bench for alu_decode_stage against a table-driven decode model and a
// one-entry queue model of the handshake, plus directed scenarios with literal values.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] dataA;
  logic [63:0] dataB;
  logic [5:0]  alu_control;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
  logic [15:0] ill_count;

  logic        satInReady;
  logic        satOutValid;
  logic [63:0] satDataA;
  logic [63:0] satDataB;
  logic [5:0]  satAluControl;
  logic [4:0]  satRd;
  logic        satRdWe;
  logic        satIllegal;
  logic [1:0]  satIllCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .dataA(dataA), .dataB(dataB), .alu_control(alu_control),
    .rd(rd), .rd_we(rd_we), .illegal(illegal), .ill_count(ill_count)
  );

  // A narrow counter lets saturation be reached in a handful of illegal loads.
  alu_decode_stage #(.ILL_CNT_WIDTH(2)) dutSat (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(satInReady),
    .in_instr(in_instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(satOutValid),
    .out_ready(out_ready), .dataA(satDataA), .dataB(satDataB), .alu_control(satAluControl),
    .rd(satRd), .rd_we(satRdWe), .illegal(satIllegal), .ill_count(satIllCount)
  );

  // Legal encodings as a flat table: operand kind 0=rs2, 1=sext imm, 2=6-bit shamt, 3=5-bit shamt.
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] mask;
    logic [6:0] f7;
    int         code;
    int         kind;
  } rule_t;

  typedef struct {
    logic [5:0]  code;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        rdWe;
    logic        ill;
  } expect_t;

  rule_t rules[$];

  task automatic addRule(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] mask,
                         input logic [6:0] f7, input int code, input int kind);
    rule_t r;
    r.opc = opc; r.f3 = f3; r.mask = mask; r.f7 = f7; r.code = code; r.kind = kind;
    rules.push_back(r);
  endtask

  task automatic buildRules();
    int opCodes[8] = '{12, 14, 15, 16, 17, 18, 20, 21};
    int iCodes[8]  = '{1, 0, 2, 3, 4, 0, 5, 6};
    for (int f = 0; f < 8; f++) begin
      if (iCodes[f] != 0) addRule(7'b0010011, 3'(f), 7'h00, 7'h00, iCodes[f], 1);
      addRule(7'b0110011, 3'(f), 7'h7F, 7'h00, opCodes[f], 0);
      addRule(7'b0110011, 3'(f), 7'h7F, 7'h01, 31 + f, 0);
    end
    addRule(7'b0010011, 3'b001, 7'h7E, 7'h00, 7, 2);
    addRule(7'b0010011, 3'b101, 7'h7E, 7'h00, 8, 2);
    addRule(7'b0010011, 3'b101, 7'h7E, 7'h20, 9, 2);
    addRule(7'b0110011, 3'b000, 7'h7F, 7'h20, 13, 0);
    addRule(7'b0110011, 3'b101, 7'h7F, 7'h20, 19, 0);
    addRule(7'b0011011, 3'b000, 7'h00, 7'h00, 22, 1);
    addRule(7'b0011011, 3'b001, 7'h7F, 7'h00, 23, 3);
    addRule(7'b0011011, 3'b101, 7'h7F, 7'h00, 24, 3);
    addRule(7'b0011011, 3'b101, 7'h7F, 7'h20, 25, 3);
    addRule(7'b0111011, 3'b000, 7'h7F, 7'h00, 26, 0);
    addRule(7'b0111011, 3'b000, 7'h7F, 7'h20, 27, 0);
    addRule(7'b0111011, 3'b001, 7'h7F, 7'h00, 28, 0);
    addRule(7'b0111011, 3'b101, 7'h7F, 7'h00, 29, 0);
    addRule(7'b0111011, 3'b101, 7'h7F, 7'h20, 30, 0);
    addRule(7'b0111011, 3'b000, 7'h7F, 7'h01, 39, 0);
    addRule(7'b0111011, 3'b100, 7'h7F, 7'h01, 40, 0);
    addRule(7'b0111011, 3'b101, 7'h7F, 7'h01, 41, 0);
    addRule(7'b0111011, 3'b110, 7'h7F, 7'h01, 42, 0);
    addRule(7'b0111011, 3'b111, 7'h7F, 7'h01, 43, 0);
  endtask

  function automatic expect_t modelDecode(input logic [31:0] instr, input logic [63:0] r1,
                                          input logic [63:0] r2);
    expect_t e;
    e.code = 6'd0; e.a = 64'd0; e.b = 64'd0; e.rd = instr[11:7]; e.rdWe = 1'b0; e.ill = 1'b1;
    foreach (rules[i]) begin
      if (instr[6:0] == rules[i].opc && instr[14:12] == rules[i].f3 &&
          (instr[31:25] & rules[i].mask) == rules[i].f7) begin
        e.ill  = 1'b0;
        e.code = 6'(rules[i].code);
        e.a    = r1;
        e.rdWe = (instr[11:7] != 5'd0);
        case (rules[i].kind)
          0:       e.b = r2;
          1:       e.b = 64'($signed(instr[31:20]));
          2:       e.b = 64'(instr[25:20]);
          default: e.b = 64'(instr[24:20]);
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    rule_t       r;
    w = $urandom;
    if ($urandom_range(0, 99) < 80) begin
      r = rules[$urandom_range(0, rules.size() - 1)];
      w[6:0]   = r.opc;
      w[14:12] = r.f3;
      w[31:25] = (w[31:25] & ~r.mask) | r.f7;
      if ($urandom_range(0, 9) == 0) w[25 + $urandom_range(0, 6)] ^= 1'b1;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [31:0] instr, input logic [63:0] r1,
                               input logic [63:0] r2, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = vld;
    in_instr  = instr;
    rs1_data  = r1;
    rs2_data  = r2;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #2;
  endtask

  // Reference pipeline: one optional entry, counters saturating at their all-ones value.
  expect_t     mNext;
  expect_t     mEntry;
  logic        mValid;
  logic [15:0] mCount;
  logic [1:0]  mSat;

  always_comb mNext = modelDecode(in_instr, rs1_data, rs2_data);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mValid <= 1'b0;
      mCount <= 16'd0;
      mSat   <= 2'd0;
    end else if (flush) begin
      mValid <= 1'b0;
    end else if (in_valid && (!mValid || out_ready)) begin
      mEntry <= mNext;
      mValid <= 1'b1;
      if (mNext.ill) begin
        if (mCount != 16'hFFFF) mCount <= mCount + 16'd1;
        if (mSat != 2'd3)       mSat   <= mSat + 2'd1;
      end
    end else if (out_ready) begin
      mValid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      checkOutput("out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("in_ready", 64'(in_ready), 64'(!mValid || out_ready));
      checkOutput("ill_count", 64'(ill_count), 64'(mCount));
      checkOutput("sat_ill_count", 64'(satIllCount), 64'(mSat));
      if (mValid) begin
        checkOutput("alu_control", 64'(alu_control), 64'(mEntry.code));
        checkOutput("dataA", dataA, mEntry.a);
        checkOutput("dataB", dataB, mEntry.b);
        checkOutput("rd", 64'(rd), 64'(mEntry.rd));
        checkOutput("rd_we", 64'(rd_we), 64'(mEntry.rdWe));
        checkOutput("illegal", 64'(illegal), 64'(mEntry.ill));
      end
    end
  end

  initial begin
    logic [31:0] addiI, sraiwI, slliwBad, addI, mulI, divuwI, badI;
    addiI    = 32'hFFF08293;
    sraiwI   = {7'b0100000, 5'd31, 5'd4, 3'b101, 5'd3, 7'b0011011};
    slliwBad = {7'b0000001, 5'd1, 5'd2, 3'b001, 5'd6, 7'b0011011};
    addI     = {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
    mulI     = {7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
    divuwI   = {7'b0000001, 5'd9, 5'd8, 3'b101, 5'd7, 7'b0111011};
    badI     = 32'hFFFF_FFFF;

    buildRules();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; rs1_data = 64'd0; rs2_data = 64'd0;
    #2;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset ill_count", 64'(ill_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b1, addiI, 64'd10, 64'd99, 1'b1, 1'b0);
    waitEdge();
    checkOutput("addi alu_control", 64'(alu_control), 64'd1);
    checkOutput("addi dataA", dataA, 64'd10);
    checkOutput("addi dataB", dataB, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi rd", 64'(rd), 64'd5);
    checkOutput("addi rd_we", 64'(rd_we), 64'd1);

    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
    checkOutput("midreset alu_control", 64'(alu_control), 64'd0);
    checkOutput("midreset dataB", dataB, 64'd0);
    checkOutput("midreset rd_we", 64'(rd_we), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; in_instr = addiI; rs1_data = 64'd7; out_ready = 1'b1;
    waitEdge();
    checkOutput("post-reset accept valid", 64'(out_valid), 64'd1);
    checkOutput("post-reset accept dataA", dataA, 64'd7);

    applyStimulus(1'b1, sraiwI, 64'd123, 64'd5, 1'b1, 1'b0);
    waitEdge();
    checkOutput("sraiw alu_control", 64'(alu_control), 64'd25);
    checkOutput("sraiw dataB", dataB, 64'd31);
    applyStimulus(1'b1, slliwBad, 64'd123, 64'd5, 1'b1, 1'b0);
    waitEdge();
    checkOutput("slliw illegal", 64'(illegal), 64'd1);
    checkOutput("slliw alu_control", 64'(alu_control), 64'd0);
    checkOutput("slliw ill_count", 64'(ill_count), 64'd1);
    checkOutput("slliw dataA", dataA, 64'd0);

    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    waitEdge();
    applyStimulus(1'b1, addI, 64'd1111, 64'd2, 1'b0, 1'b0);
    waitEdge();
    checkOutput("add alu_control", 64'(alu_control), 64'd12);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mulI, 64'd3333, 64'd4, 1'b0, 1'b0);
      waitEdge();
      checkOutput("stall alu_control", 64'(alu_control), 64'd12);
      checkOutput("stall dataA", dataA, 64'd1111);
      checkOutput("stall in_ready", 64'(in_ready), 64'd0);
    end
    applyStimulus(1'b1, mulI, 64'd3333, 64'd4, 1'b1, 1'b0);
    waitEdge();
    checkOutput("mul alu_control", 64'(alu_control), 64'd31);
    applyStimulus(1'b1, divuwI, 64'd5555, 64'd6, 1'b1, 1'b0);
    waitEdge();
    checkOutput("divuw alu_control", 64'(alu_control), 64'd41);
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    waitEdge();
    checkOutput("drain out_valid", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, addI, 64'd1, 64'd2, 1'b0, 1'b0);
    waitEdge();
    checkOutput("preflush out_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, badI, 64'd1, 64'd2, 1'b0, 1'b1);
    waitEdge();
    checkOutput("flush out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush ill_count", 64'(ill_count), 64'd1);
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    waitEdge();
    checkOutput("postflush out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'd0, 64'd9, 64'd9, 1'b1, 1'b0);
      waitEdge();
      if (i == 1) checkOutput("sat reaches max", 64'(satIllCount), 64'd3);
    end
    checkOutput("sat holds max", 64'(satIllCount), 64'd3);
    checkOutput("wide ill_count", 64'(ill_count), 64'd5);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, genInstr(), {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5);
    end
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    repeat (3) waitEdge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
